disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Double-buffered digit data is committed once per frame.
// Each digit is shown for 2^DIV_W clocks, followed by GAP_CYC dead clocks.
// Ports: clk, rst (async, active-high), en, ld, din[15:0], dp_in[3:0],
//        blank_in[3:0] -> d_out[3:0], le, pt, an[3:0] (active-low),
//        pend, frame_tick. All outputs are registered.
// Optional macro SCAN_BLANK_ZERO_EN: leading-zero suppression on digits 3..1.
module disp_scan_ctrl #(
    parameter int DIV_W   = 17,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ld,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  d_out,
    output logic        le,
    output logic        pt,
    output logic [3:0]  an,
    output logic        pend,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_GAP
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = '1;
    localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYC - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nx;
    logic [DIV_W-1:0]  r_presc;
    logic [DIV_W-1:0]  w_presc_nx;
    logic [3:0]        r_gcnt;
    logic [3:0]        w_gcnt_nx;
    logic              w_commit;

    logic [15:0]       r_act_d;
    logic [3:0]        r_act_dp;
    logic [3:0]        r_act_bl;
    logic [15:0]       r_sh_d;
    logic [3:0]        r_sh_dp;
    logic [3:0]        r_sh_bl;
    logic              r_pend;
    logic              r_tick;

    logic [15:0]       w_act_d;
    logic [3:0]        w_act_dp;
    logic [3:0]        w_act_bl;
    logic [3:0]        w_digit;
    logic              w_zb;

    logic [3:0]        r_an;
    logic              r_le;
    logic              r_pt;
    logic [3:0]        r_d;
    logic [3:0]        w_an_nx;
    logic              w_le_nx;
    logic              w_pt_nx;
    logic [3:0]        w_d_nx;

    // Next-state logic. en low wins over every other transition.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_presc_nx = r_presc;
        w_gcnt_nx  = r_gcnt;
        w_commit   = 1'b0;
        if (!en) begin
            w_state_nx = ST_OFF;
        end else begin
            unique case (r_state)
                ST_OFF: begin
                    w_state_nx = ST_SHOW;
                    w_idx_nx   = 2'd0;
                    w_presc_nx = '0;
                    w_commit   = 1'b1;
                end
                ST_SHOW: begin
                    if (r_presc == PRESC_MAX) begin
                        w_state_nx = ST_GAP;
                        w_presc_nx = '0;
                        w_gcnt_nx  = 4'd0;
                    end else begin
                        w_presc_nx = r_presc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        w_state_nx = ST_SHOW;
                        w_idx_nx   = r_idx + 2'd1;
                        w_gcnt_nx  = 4'd0;
                        w_commit   = (r_idx == 2'd3);
                    end else begin
                        w_gcnt_nx = r_gcnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_OFF;
                end
            endcase
        end
    end

    // Active data as it will be after this edge, so the outputs
    // registered on the commit edge already reflect the new frame.
    always_comb begin
        w_act_d  = r_act_d;
        w_act_dp = r_act_dp;
        w_act_bl = r_act_bl;
        if (w_commit) begin
            w_act_d  = r_sh_d;
            w_act_dp = r_sh_dp;
            w_act_bl = r_sh_bl;
        end
    end

    assign w_digit = w_act_d[{w_idx_nx, 2'b00} +: 4];

`ifdef SCAN_BLANK_ZERO_EN
    // w_lz[k]: active digits k..3 are all zero; digit 0 never suppressed.
    logic [3:0] w_lz;
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (w_act_d[15:12] == 4'h0);
        w_lz[2] = w_lz[3] && (w_act_d[11:8] == 4'h0);
        w_lz[1] = w_lz[2] && (w_act_d[7:4] == 4'h0);
    end
    assign w_zb = w_lz[w_idx_nx];
`else
    assign w_zb = 1'b0;
`endif

    // Outputs are computed from next state so anode and data move together.
    always_comb begin
        w_an_nx = 4'b1111;
        w_le_nx = 1'b1;
        w_pt_nx = 1'b0;
        w_d_nx  = r_d;
        unique case (w_state_nx)
            ST_OFF: begin
                w_d_nx = 4'h0;
            end
            ST_SHOW: begin
                w_an_nx = ~(4'b0001 << w_idx_nx);
                w_d_nx  = w_digit;
                w_pt_nx = w_act_dp[w_idx_nx];
                w_le_nx = w_act_bl[w_idx_nx] | w_zb;
            end
            ST_GAP: begin
                w_d_nx = r_d;
            end
            default: begin
                w_d_nx = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_idx    <= 2'd0;
            r_presc  <= '0;
            r_gcnt   <= 4'd0;
            r_act_d  <= 16'h0;
            r_act_dp <= 4'h0;
            r_act_bl <= 4'h0;
            r_sh_d   <= 16'h0;
            r_sh_dp  <= 4'h0;
            r_sh_bl  <= 4'h0;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_an     <= 4'b1111;
            r_le     <= 1'b1;
            r_pt     <= 1'b0;
            r_d      <= 4'h0;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_presc  <= w_presc_nx;
            r_gcnt   <= w_gcnt_nx;
            r_act_d  <= w_act_d;
            r_act_dp <= w_act_dp;
            r_act_bl <= w_act_bl;
            r_tick   <= w_commit;
            r_an     <= w_an_nx;
            r_le     <= w_le_nx;
            r_pt     <= w_pt_nx;
            r_d      <= w_d_nx;
            // A load on the commit edge keeps pend set for the next frame.
            if (ld) begin
                r_sh_d  <= din;
                r_sh_dp <= dp_in;
                r_sh_bl <= blank_in;
                r_pend  <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign le         = r_le;
    assign pt         = r_pt;
    assign d_out      = r_d;
    assign pend       = r_pend;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl (DIV_W=2, GAP_CYC=2).
// Frame-position reference model; random and directed scenarios.
module tb_disp_scan_ctrl;

    localparam int DW    = 2;
    localparam int GC    = 2;
    localparam int S     = 1 << DW;
    localparam int P     = S + GC;
    localparam int FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ld;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  d_out;
    logic        le;
    logic        pt;
    logic [3:0]  an;
    logic        pend;
    logic        frame_tick;

    disp_scan_ctrl #(.DIV_W(DW), .GAP_CYC(GC)) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .din(din),
        .dp_in(dp_in), .blank_in(blank_in), .d_out(d_out), .le(le),
        .pt(pt), .an(an), .pend(pend), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: running flag plus position within the frame.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_abl, m_sdp, m_sbl;
    bit          m_pend, m_ft;

    task automatic mdl_reset();
        m_run = 0; m_pos = 0;
        m_act = 0; m_adp = 0; m_abl = 0;
        m_sh = 0; m_sdp = 0; m_sbl = 0;
        m_pend = 0; m_ft = 0;
    endtask

    task automatic mdl_edge(input bit e, input bit l, input logic [15:0] d,
                            input logic [3:0] dp, input logic [3:0] bl);
        bit c;
        c = 0;
        if (!e) m_run = 0;
        else if (!m_run) begin
            m_run = 1; m_pos = 0; c = 1;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            c = (m_pos == 0);
        end
        if (c) begin
            m_act = m_sh; m_adp = m_sdp; m_abl = m_sbl;
        end
        if (l) begin
            m_sh = d; m_sdp = dp; m_sbl = bl; m_pend = 1;
        end else if (c) m_pend = 0;
        m_ft = c;
    endtask

    function automatic bit zb(int k);
`ifdef SCAN_BLANK_ZERO_EN
        return (k > 0) && ((m_act >> (4 * k)) == 16'h0);
`else
        return (k < 0);
`endif
    endfunction

    // {an, le, pt, d_out, pend, frame_tick}
    function automatic logic [11:0] mdl_out();
        logic [3:0] a, d;
        logic       l, p;
        int         k, w;
        a = 4'hF; l = 1'b1; p = 1'b0; d = 4'h0;
        if (m_run) begin
            k = m_pos / P;
            w = m_pos % P;
            d = m_act[4*k +: 4];
            if (w < S) begin
                a = ~(4'b0001 << k);
                p = m_adp[k];
                l = m_abl[k] | zb(k);
            end
        end
        return {a, l, p, d, m_pend, m_ft};
    endfunction

    task automatic cyc(input bit e, input bit l, input logic [15:0] d,
                       input logic [3:0] dp, input logic [3:0] bl);
        en = e; ld = l; din = d; dp_in = dp; blank_in = bl;
        @(posedge clk);
        mdl_edge(e, l, d, dp, bl);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ld = 1'b0;
        din = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        mdl_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({an, le, pt, d_out, pend, frame_tick} !== 12'b1111_1_0_0000_0_0) begin
            n_err++;
            $display("FAIL reset got=%h exp=%h",
                     {an, le, pt, d_out, pend, frame_tick}, 12'hF80);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        n_vec++;
        if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
            n_err++;
            $display("FAIL reset_idle got=%h exp=%h",
                     {an, le, pt, d_out, pend, frame_tick}, mdl_out());
        end
    endtask

    task automatic test_scan();
        int len;
        bit seen;
        cyc(0, 1, 16'h12AF, 4'h0, 4'h0);
        n_vec++;
        if (pend !== 1'b1) begin
            n_err++; $display("FAIL scan_pend got=%b exp=1", pend);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            cyc(1, 0, 0, 0, 0);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL scan c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
        // Measure one frame between consecutive ticks.
        len = 0; seen = 0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            cyc(1, 0, 0, 0, 0);
            len++;
            if (frame_tick === 1'b1) seen = 1;
        end
        len = 0; seen = 0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            cyc(1, 0, 0, 0, 0);
            len++;
            if (frame_tick === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || len != FRAME) begin
            n_err++;
            $display("FAIL frame_len got=%0d exp=%0d", len, FRAME);
        end
    endtask

    // Advance until model sits at frame position tgt (running).
    task automatic goto_pos(input int tgt, input string tag);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == tgt) && guard < 4 * FRAME) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        n_vec++;
        if (guard >= 4 * FRAME) begin
            n_err++;
            $display("FAIL %s timeout got=%0d exp=%0d", tag, m_pos, tgt);
        end
    endtask

    task automatic test_load_pend();
        goto_pos(P + 1, "ldpend");
        cyc(1, 1, 16'h0005, 4'h0, 4'h0);
        n_vec++;
        if (pend !== 1'b1) begin
            n_err++; $display("FAIL ldpend_pend got=%b exp=1", pend);
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            cyc(1, 0, 0, 0, 0);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL ldpend c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
    endtask

    task automatic test_back_to_back();
        goto_pos(FRAME - 1, "b2b");
        cyc(1, 1, 16'h3C4D, 4'h5, 4'h0);
        n_vec++;
        if ({pend, frame_tick} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_edge got=%b exp=11", {pend, frame_tick});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1, 0, 0, 0, 0);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL b2b c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
    endtask

    task automatic test_enable();
        goto_pos(2 * P + 1, "en");
        cyc(0, 0, 0, 0, 0);
        n_vec++;
        if ({an, le} !== 5'b1111_1) begin
            n_err++; $display("FAIL en_off got=%b exp=11111", {an, le});
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        n_vec++;
        if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()
            || frame_tick !== 1'b1 || an !== 4'b1110) begin
            n_err++;
            $display("FAIL en_restart got=%h exp=%h",
                     {an, le, pt, d_out, pend, frame_tick}, mdl_out());
        end
    endtask

    task automatic test_zero_blank();
        cyc(0, 1, 16'h0070, 4'b0010, 4'b0000);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < FRAME; i++) begin
            cyc(1, 0, 0, 0, 0);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL zblank c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        cyc(1, 1, 16'hBEEF, 4'hA, 4'h0);
        guard = 0;
        while (!(m_run && (m_pos % P) >= S) && guard < FRAME) begin
            cyc(1, 0, 0, 0, 0);
            guard++;
        end
        n_vec++;
        if (an !== 4'b1111 || pend !== 1'b1 || guard >= FRAME) begin
            n_err++;
            $display("FAIL arst_pre got=%b%b exp=11111", an, pend);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({an, le, pt, d_out, pend, frame_tick} !== 12'b1111_1_0_0000_0_0) begin
            n_err++;
            $display("FAIL arst got=%h exp=%h",
                     {an, le, pt, d_out, pend, frame_tick}, 12'hF80);
        end
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            cyc(1, 0, 0, 0, 0);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL arst_post c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
    endtask

    task automatic test_random();
        bit         e, l;
        logic [15:0] d;
        logic [3:0]  dp, bl;
        e = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 60) == 0) e = ~e;
            l  = ($urandom_range(0, 15) == 0);
            d  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            dp = 4'($urandom);
            bl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc(e, l, d, dp, bl);
            n_vec++;
            if ({an, le, pt, d_out, pend, frame_tick} !== mdl_out()) begin
                n_err++;
                $display("FAIL rand c%0d got=%h exp=%h", i,
                         {an, le, pt, d_out, pend, frame_tick}, mdl_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_pend();
        test_back_to_back();
        test_enable();
        test_zero_blank();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
